// File: rtl/pid_sched_pkg.sv
// Shared widths, axis indices and FSM encoding for the PID frame scheduler.
package pid_sched_pkg;
   localparam int NUM_AXES = 3;
   localparam int DATA_W   = 32;
   localparam int DIV_W    = 4;
   localparam int TO_W     = 16;

   typedef enum logic [1:0] {
      AX_ROLL  = 2'd0,
      AX_PITCH = 2'd1,
      AX_YAW   = 2'd2
   } axis_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_COMMIT = 3'd4,
      ST_FAULT  = 3'd5
   } sched_state_e;
endpackage

// File: rtl/pid_scheduler_if.sv
// Handshake bundle between the scheduler (master) and the three PID instances (slave).
interface pid_scheduler_if;
   import pid_sched_pkg::*;

   logic [NUM_AXES-1:0]             pid_start;
   logic [NUM_AXES-1:0][DATA_W-1:0] pid_error;
   logic [NUM_AXES-1:0][DATA_W-1:0] pid_delta_t;
   logic [NUM_AXES-1:0]             pid_done;
   logic [NUM_AXES-1:0][DATA_W-1:0] pid_out;

   modport master (
      output pid_start, pid_error, pid_delta_t,
      input  pid_done, pid_out
   );

   modport slave (
      input  pid_start, pid_error, pid_delta_t,
      output pid_done, pid_out
   );
endinterface

// File: rtl/sched_rate_div.sv
// Per-axis tick divider: axis is due when enabled and its count is zero.
module sched_rate_div
   import pid_sched_pkg::*;
(
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             adv,
   input  logic             axis_en,
   input  logic [DIV_W-1:0] rate_div,
   output logic             due
);
   logic [DIV_W-1:0] cnt_d, cnt_q;

   assign due = axis_en && (cnt_q == '0);

   // advanced once per accepted frame, after the due decision has been taken
   always_comb begin
      cnt_d = cnt_q;
      if (!axis_en)
         cnt_d = '0;
      else if (adv)
         cnt_d = (cnt_q == '0) ? rate_div : cnt_q - DIV_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!nrst)
         cnt_q <= '0;
      else if (en)
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pid_scheduler.sv
// Frame scheduler: on each tick, latches error/delta_t for due axes, starts the
// PID instances, waits for completion (with optional timeout) and commits results.
module pid_scheduler
   import pid_sched_pkg::*;
(
   input  logic                             clk,
   input  logic                             nrst,
   input  logic                             en,
   input  logic                             tick,
   input  logic [NUM_AXES-1:0]              axis_en,
   input  logic [NUM_AXES-1:0][DIV_W-1:0]   rate_div,
   input  logic [TO_W-1:0]                  timeout_cyc,
   input  logic                             clr_fault,
   input  logic [NUM_AXES-1:0][DATA_W-1:0]  err_in,
   pid_scheduler_if.master                  pid,
   output logic [NUM_AXES-1:0][DATA_W-1:0]  ctrl_out,
   output logic [NUM_AXES-1:0]              ctrl_valid,
   output logic                             frame_done,
   output logic                             busy,
   output logic                             overrun,
   output logic                             timeout_fault
);
   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_LATCH  = ST_LATCH;
   localparam logic [2:0] S_START  = ST_START;
   localparam logic [2:0] S_WAIT   = ST_WAIT;
   localparam logic [2:0] S_COMMIT = ST_COMMIT;
   localparam logic [2:0] S_FAULT  = ST_FAULT;

   logic [2:0]                       state_d, state_q;
   logic [DATA_W-1:0]                cyc_d, cyc_q;
   logic [NUM_AXES-1:0][DATA_W-1:0]  stamp_d, stamp_q;
   logic [NUM_AXES-1:0]              started_d, started_q;
   logic [NUM_AXES-1:0]              due_d, due_q;
   logic [NUM_AXES-1:0]              done_mask_d, done_mask_q;
   logic [TO_W-1:0]                  to_cnt_d, to_cnt_q;
   logic                             wait_first_d, wait_first_q;
   logic [NUM_AXES-1:0]              pid_start_d, pid_start_q;
   logic [NUM_AXES-1:0][DATA_W-1:0]  pid_error_d, pid_error_q;
   logic [NUM_AXES-1:0][DATA_W-1:0]  pid_delta_d, pid_delta_q;
   logic [NUM_AXES-1:0][DATA_W-1:0]  ctrl_out_d, ctrl_out_q;
   logic [NUM_AXES-1:0]              ctrl_valid_d, ctrl_valid_q;
   logic                             frame_done_d, frame_done_q;
   logic                             overrun_d, overrun_q;
   logic                             timeout_fault_d, timeout_fault_q;
   logic [NUM_AXES-1:0]              due_now;

   for (genvar g = 0; g < NUM_AXES; g++) begin : g_div
      sched_rate_div u_div (
         .clk      (clk),
         .nrst     (nrst),
         .en       (en),
         .adv      (state_q == S_LATCH),
         .axis_en  (axis_en[g]),
         .rate_div (rate_div[g]),
         .due      (due_now[g])
      );
   end

   always_comb begin
      state_d         = state_q;
      cyc_d           = cyc_q + DATA_W'(1);
      stamp_d         = stamp_q;
      started_d       = started_q;
      due_d           = due_q;
      done_mask_d     = done_mask_q;
      to_cnt_d        = to_cnt_q;
      wait_first_d    = wait_first_q;
      pid_start_d     = '0;
      pid_error_d     = pid_error_q;
      pid_delta_d     = pid_delta_q;
      ctrl_out_d      = ctrl_out_q;
      ctrl_valid_d    = '0;
      frame_done_d    = 1'b0;
      overrun_d       = overrun_q & ~clr_fault;
      timeout_fault_d = timeout_fault_q & ~clr_fault;

      if (tick && state_q != S_IDLE)
         overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (tick)
               state_d = S_LATCH;
         end
         S_LATCH: begin
            due_d       = due_now;
            pid_start_d = due_now;
            // delta_t spans start-to-start; START happens at cyc_q + 1
            for (int a = 0; a < NUM_AXES; a++) begin
               if (due_now[a]) begin
                  pid_error_d[a] = err_in[a];
                  pid_delta_d[a] = started_q[a] ? (cyc_q + DATA_W'(1) - stamp_q[a]) : '0;
               end
            end
            state_d = (due_now == '0) ? S_COMMIT : S_START;
         end
         S_START: begin
            for (int a = 0; a < NUM_AXES; a++) begin
               if (due_q[a]) begin
                  stamp_d[a]   = cyc_q;
                  started_d[a] = 1'b1;
               end
            end
            to_cnt_d     = '0;
            done_mask_d  = '0;
            wait_first_d = 1'b1;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            // first WAIT cycle may still see a stale done level from the last frame
            wait_first_d = 1'b0;
            if (!wait_first_q)
               done_mask_d = done_mask_q | (pid.pid_done & due_q);
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (done_mask_d == due_q)
               state_d = S_COMMIT;
            else if (timeout_cyc != '0 && to_cnt_d == timeout_cyc)
               state_d = S_FAULT;
         end
         S_COMMIT: begin
            for (int a = 0; a < NUM_AXES; a++)
               if (due_q[a])
                  ctrl_out_d[a] = pid.pid_out[a];
            ctrl_valid_d = due_q;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
         end
         S_FAULT: begin
            timeout_fault_d = 1'b1;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q         <= S_IDLE;
         cyc_q           <= '0;
         stamp_q         <= '0;
         started_q       <= '0;
         due_q           <= '0;
         done_mask_q     <= '0;
         to_cnt_q        <= '0;
         wait_first_q    <= 1'b0;
         pid_start_q     <= '0;
         pid_error_q     <= '0;
         pid_delta_q     <= '0;
         ctrl_out_q      <= '0;
         ctrl_valid_q    <= '0;
         frame_done_q    <= 1'b0;
         overrun_q       <= 1'b0;
         timeout_fault_q <= 1'b0;
      end else if (en) begin
         state_q         <= state_d;
         cyc_q           <= cyc_d;
         stamp_q         <= stamp_d;
         started_q       <= started_d;
         due_q           <= due_d;
         done_mask_q     <= done_mask_d;
         to_cnt_q        <= to_cnt_d;
         wait_first_q    <= wait_first_d;
         pid_start_q     <= pid_start_d;
         pid_error_q     <= pid_error_d;
         pid_delta_q     <= pid_delta_d;
         ctrl_out_q      <= ctrl_out_d;
         ctrl_valid_q    <= ctrl_valid_d;
         frame_done_q    <= frame_done_d;
         overrun_q       <= overrun_d;
         timeout_fault_q <= timeout_fault_d;
      end
   end

   assign pid.pid_start   = pid_start_q;
   assign pid.pid_error   = pid_error_q;
   assign pid.pid_delta_t = pid_delta_q;
   assign ctrl_out        = ctrl_out_q;
   assign ctrl_valid      = ctrl_valid_q;
   assign frame_done      = frame_done_q;
   assign busy            = (state_q != S_IDLE);
   assign overrun         = overrun_q;
   assign timeout_fault   = timeout_fault_q;
endmodule

// File: tb/tb_pid_scheduler.sv
// Directed bench for pid_scheduler: frame table plus sequences for latency,
// delta_t, overrun, enable hold and mid-frame reset.
module tb_pid_scheduler;
   import pid_sched_pkg::*;

   localparam logic [31:0] K = 32'h5A5A_0000;

   logic                             clk = 1'b0;
   logic                             nrst, en, tick, clr_fault;
   logic [NUM_AXES-1:0]              axis_en;
   logic [NUM_AXES-1:0][DIV_W-1:0]   rate_div;
   logic [TO_W-1:0]                  timeout_cyc;
   logic [NUM_AXES-1:0][DATA_W-1:0]  err_in;
   logic [NUM_AXES-1:0][DATA_W-1:0]  ctrl_out;
   logic [NUM_AXES-1:0]              ctrl_valid;
   logic                             frame_done, busy, overrun, timeout_fault;

   pid_scheduler_if pif ();

   pid_scheduler dut (
      .clk           (clk),
      .nrst          (nrst),
      .en            (en),
      .tick          (tick),
      .axis_en       (axis_en),
      .rate_div      (rate_div),
      .timeout_cyc   (timeout_cyc),
      .clr_fault     (clr_fault),
      .err_in        (err_in),
      .pid           (pif),
      .ctrl_out      (ctrl_out),
      .ctrl_valid    (ctrl_valid),
      .frame_done    (frame_done),
      .busy          (busy),
      .overrun       (overrun),
      .timeout_fault (timeout_fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // PID model: done goes high lat[a] cycles after the start cycle (lat 0 = never)
   int lat [3];
   int pcnt [3];
   always @(posedge clk) begin
      if (!nrst) begin
         for (int a = 0; a < 3; a++) begin
            pcnt[a]         <= 0;
            pif.pid_done[a] <= 1'b0;
            pif.pid_out[a]  <= '0;
         end
      end else begin
         for (int a = 0; a < 3; a++) begin
            if (pif.pid_start[a]) begin
               pif.pid_done[a] <= 1'b0;
               pcnt[a]         <= (lat[a] > 0) ? lat[a] - 1 : 0;
            end else if (pcnt[a] != 0) begin
               pcnt[a] <= pcnt[a] - 1;
               if (pcnt[a] == 1) begin
                  pif.pid_done[a] <= 1'b1;
                  pif.pid_out[a]  <= pif.pid_error[a] ^ K;
               end
            end
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame(output logic fd, output logic [2:0] vld, output int fcyc, output int n);
      fd = 1'b0; vld = '0; fcyc = 0; n = 0;
      while (n < 300) begin
         step();
         n++;
         if (frame_done) begin
            fd   = 1'b1;
            vld  = ctrl_valid;
            fcyc = cyc;
         end
         if (!busy) break;
      end
      chk("frame_end_busy", {127'd0, busy}, 128'd0);
   endtask

   typedef struct {
      logic [2:0]  ax;
      logic [3:0]  ydiv;
      logic [15:0] to;
      int          lat_p;
      logic [2:0]  e_start;
      logic [2:0]  e_vld;
      logic        e_fault;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [NUM_AXES-1:0][DATA_W-1:0] exp_ctrl;
      logic       fd;
      logic [2:0] vld;
      int         fcyc, n, t0;

      tbl[0] = '{3'b111, 4'd1, 16'd0,  5, 3'b111, 3'b111, 1'b0};
      tbl[1] = '{3'b111, 4'd1, 16'd0,  5, 3'b011, 3'b011, 1'b0};
      tbl[2] = '{3'b111, 4'd1, 16'd0,  5, 3'b111, 3'b111, 1'b0};
      tbl[3] = '{3'b111, 4'd1, 16'd0,  5, 3'b011, 3'b011, 1'b0};
      tbl[4] = '{3'b000, 4'd0, 16'd0,  5, 3'b000, 3'b000, 1'b0};
      tbl[5] = '{3'b010, 4'd0, 16'd0,  5, 3'b010, 3'b010, 1'b0};
      tbl[6] = '{3'b111, 4'd0, 16'd20, 0, 3'b111, 3'b000, 1'b1};

      nrst = 1'b0; en = 1'b1; tick = 1'b0; clr_fault = 1'b0;
      axis_en = 3'b111; rate_div = '0; timeout_cyc = '0; err_in = '0;
      lat[0] = 40; lat[1] = 40; lat[2] = 40;
      exp_ctrl = '0;
      repeat (3) step();

      chk("rst_busy",       {127'd0, busy},          128'd0);
      chk("rst_pid_start",  {125'd0, pif.pid_start}, 128'd0);
      chk("rst_ctrl_out",   {32'd0, ctrl_out},       128'd0);
      chk("rst_flags",      {124'd0, frame_done, ctrl_valid == 3'b000 ? 1'b0 : 1'b1, overrun, timeout_fault}, 128'd0);
      nrst = 1'b1;
      step();

      // first frame: latency and never-started delta_t
      err_in[0] = 32'h0000_0011; err_in[1] = 32'h8000_0022; err_in[2] = 32'h0000_0033;
      t0 = cyc; tick = 1'b1; step(); tick = 1'b0; step();
      chk("a_pid_start",  {125'd0, pif.pid_start}, 128'd7);
      chk("a_delta_zero", {32'd0, pif.pid_delta_t}, 128'd0);
      chk("a_pid_error",  {32'd0, pif.pid_error},   {32'd0, err_in});
      wait_frame(fd, vld, fcyc, n);
      for (int a = 0; a < 3; a++) exp_ctrl[a] = err_in[a] ^ K;
      chk("a_done_cycle", 128'(fcyc - t0), 128'd44);
      chk("a_valid",      {125'd0, vld},   128'd7);
      chk("a_ctrl_out",   {32'd0, ctrl_out}, {32'd0, exp_ctrl});

      // second tick 100 cycles later
      while (cyc < t0 + 100) step();
      tick = 1'b1; step(); tick = 1'b0; step();
      chk("b_start_cycle", 128'(cyc - t0), 128'd102);
      chk("b_pid_start",   {125'd0, pif.pid_start}, 128'd7);
      chk("b_delta_100",   {32'd0, pif.pid_delta_t}, {32'd0, 32'd100, 32'd100, 32'd100});
      wait_frame(fd, vld, fcyc, n);

      lat[0] = 5; lat[2] = 5;
      for (int i = 0; i < 7; i++) begin
         axis_en     = tbl[i].ax;
         rate_div    = '0;
         rate_div[2] = tbl[i].ydiv;
         timeout_cyc = tbl[i].to;
         lat[1]      = tbl[i].lat_p;
         for (int a = 0; a < 3; a++) err_in[a] = 32'h100 * (i + 1) + 32'(a);
         tick = 1'b1; step(); tick = 1'b0; step();
         chk($sformatf("v%0d_pid_start", i), {125'd0, pif.pid_start}, {125'd0, tbl[i].e_start});
         wait_frame(fd, vld, fcyc, n);
         for (int a = 0; a < 3; a++) if (tbl[i].e_vld[a]) exp_ctrl[a] = err_in[a] ^ K;
         chk($sformatf("v%0d_frame_done", i), {127'd0, fd},  {127'd0, ~tbl[i].e_fault});
         chk($sformatf("v%0d_valid", i),      {125'd0, vld}, {125'd0, tbl[i].e_vld});
         chk($sformatf("v%0d_ctrl_out", i),   {32'd0, ctrl_out}, {32'd0, exp_ctrl});
         chk($sformatf("v%0d_tfault", i),     {127'd0, timeout_fault}, {127'd0, tbl[i].e_fault});
         if (tbl[i].e_fault)
            chk($sformatf("v%0d_fault_within22", i), {127'd0, n <= 22}, 128'd1);
      end
      clr_fault = 1'b1; step(); clr_fault = 1'b0;
      chk("tfault_cleared", {127'd0, timeout_fault}, 128'd0);

      // overrun during WAIT, set beats simultaneous clear; en low holds state
      axis_en = 3'b111; rate_div = '0; timeout_cyc = '0;
      lat[0] = 20; lat[1] = 20; lat[2] = 20;
      for (int a = 0; a < 3; a++) err_in[a] = 32'hC000_0000 + 32'(a);
      tick = 1'b1; step(); tick = 1'b0; step();
      en = 1'b0; repeat (3) step();
      chk("en_hold_start", {125'd0, pif.pid_start}, 128'd7);
      chk("en_hold_busy",  {127'd0, busy},          128'd1);
      en = 1'b1; step(); step();
      tick = 1'b1; clr_fault = 1'b1; step(); tick = 1'b0; clr_fault = 1'b0;
      chk("overrun_set", {127'd0, overrun}, 128'd1);
      wait_frame(fd, vld, fcyc, n);
      for (int a = 0; a < 3; a++) exp_ctrl[a] = err_in[a] ^ K;
      chk("ovr_frame_valid", {125'd0, vld}, 128'd7);
      chk("ovr_ctrl_out",    {32'd0, ctrl_out}, {32'd0, exp_ctrl});
      clr_fault = 1'b1; step(); clr_fault = 1'b0;
      chk("overrun_cleared", {127'd0, overrun}, 128'd0);

      // reset during WAIT aborts the frame
      tick = 1'b1; step(); tick = 1'b0; step();
      repeat (5) step();
      nrst = 1'b0; step(); nrst = 1'b1;
      chk("mr_busy",      {127'd0, busy},           128'd0);
      chk("mr_pid_start", {125'd0, pif.pid_start},  128'd0);
      chk("mr_pid_error", {32'd0, pif.pid_error},   128'd0);
      chk("mr_ctrl_out",  {32'd0, ctrl_out},        128'd0);
      chk("mr_valid",     {124'd0, ctrl_valid, frame_done}, 128'd0);
      exp_ctrl = '0;
      step();
      tick = 1'b1; step(); tick = 1'b0; step();
      chk("mr_restart",    {125'd0, pif.pid_start},  128'd7);
      chk("mr_delta_zero", {32'd0, pif.pid_delta_t}, 128'd0);
      wait_frame(fd, vld, fcyc, n);
      chk("mr_frame_valid", {125'd0, vld}, 128'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
